// File: rtl/crp16_cond_unit.sv
// ============================================================================
// Module   : crp16_cond_unit
// Purpose  : CRP16 V/C/N/Z flag register, flag save stack and branch-condition
//            resolver with a valid/ready request -> result handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crp16_cond_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             flags_we,
    input  logic [3:0]       flag_mask,
    input  logic             flags_push,
    input  logic             flags_pop,
    input  logic             cond_valid,
    input  logic [3:0]       cond_code,
    output logic             cond_ready,
    output logic             res_valid,
    output logic             res_taken,
    input  logic             res_ready,
    output logic [3:0]       flags_out,
    output logic [PTR_W:0]   stack_count,
    output logic             stack_err
);

    localparam logic [PTR_W:0] C_DEPTH = STACK_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] C_ONE   = {{PTR_W{1'b0}}, 1'b1};

    logic [3:0]     r_flags;
    logic [3:0]     r_stack [STACK_DEPTH];
    logic [PTR_W:0] r_count;
    logic           r_err;
    logic           r_res_valid;
    logic           r_res_taken;

    logic [3:0]     w_alu;
    logic [3:0]     w_next_flags;
    logic [PTR_W:0] w_count_m1;
    logic           w_push_only;
    logic           w_pop_only;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_accept;
    logic           w_cond;

    assign w_alu       = {alu_v, alu_c, alu_n, alu_z};
    assign w_push_only = flags_push & ~flags_pop;
    assign w_pop_only  = flags_pop & ~flags_push;
    assign w_do_push   = w_push_only & (r_count < C_DEPTH);
    assign w_do_pop    = w_pop_only & (r_count != '0);
    assign w_count_m1  = r_count - C_ONE;

    // A restore from the stack takes precedence over a same-cycle ALU load.
    always_comb begin
        w_next_flags = r_flags;
        if (w_do_pop) begin
            w_next_flags = r_stack[w_count_m1[PTR_W-1:0]];
        end else if (flags_we) begin
            w_next_flags = (flag_mask & w_alu) | (~flag_mask & r_flags);
        end
    end

    // Conditions see the forwarded flags so a same-cycle update is visible.
    always_comb begin
        logic v, c, n, z;
        {v, c, n, z} = w_next_flags;
        w_cond = 1'b0;
        case (cond_code)
            4'd0:    w_cond = 1'b1;
            4'd1:    w_cond = z;
            4'd2:    w_cond = ~z;
            4'd3:    w_cond = c;
            4'd4:    w_cond = ~c;
            4'd5:    w_cond = n;
            4'd6:    w_cond = ~n;
            4'd7:    w_cond = v;
            4'd8:    w_cond = ~v;
            4'd9:    w_cond = c & ~z;
            4'd10:   w_cond = ~c | z;
            4'd11:   w_cond = (n == v);
            4'd12:   w_cond = (n != v);
            4'd13:   w_cond = ~z & (n == v);
            4'd14:   w_cond = z | (n != v);
            default: w_cond = 1'b0;
        endcase
    end

    assign cond_ready = ~r_res_valid | res_ready;
    assign w_accept   = cond_valid & cond_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_flags     <= 4'b0000;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_taken <= 1'b0;
        end else begin
            r_flags <= w_next_flags;
            if (w_do_push) begin
                r_count <= r_count + C_ONE;
            end else if (w_do_pop) begin
                r_count <= w_count_m1;
            end
            if ((w_push_only && !w_do_push) || (w_pop_only && !w_do_pop)) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_res_taken <= w_cond;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Stack contents need no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_stack[r_count[PTR_W-1:0]] <= r_flags;
        end
    end

    assign flags_out   = r_flags;
    assign stack_count = r_count;
    assign stack_err   = r_err;
    assign res_valid   = r_res_valid;
    assign res_taken   = r_res_taken;

endmodule

`default_nettype wire

// File: tb/tb_crp16_cond_unit.sv
// ============================================================================
// Module   : tb_crp16_cond_unit
// Purpose  : Directed self-checking bench for crp16_cond_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crp16_cond_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       alu_v, alu_c, alu_n, alu_z;
    logic       flags_we;
    logic [3:0] flag_mask;
    logic       flags_push, flags_pop;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       cond_ready;
    logic       res_valid, res_taken, res_ready;
    logic [3:0] flags_out;
    logic [2:0] stack_count;
    logic       stack_err;

    int passes = 0;
    int total  = 0;

    crp16_cond_unit #(.STACK_DEPTH(4), .PTR_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .flags_we    (flags_we),
        .flag_mask   (flag_mask),
        .flags_push  (flags_push),
        .flags_pop   (flags_pop),
        .cond_valid  (cond_valid),
        .cond_code   (cond_code),
        .cond_ready  (cond_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_ready   (res_ready),
        .flags_out   (flags_out),
        .stack_count (stack_count),
        .stack_err   (stack_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        {alu_v, alu_c, alu_n, alu_z} = 4'b0000;
        flags_we   = 1'b0;
        flag_mask  = 4'b0000;
        flags_push = 1'b0;
        flags_pop  = 1'b0;
        cond_valid = 1'b0;
        cond_code  = 4'd0;
        res_ready  = 1'b1;
    endtask

    // Full-mask ALU load of flags {v,c,n,z} for one cycle.
    task automatic load(input logic [3:0] f);
        flags_we  = 1'b1;
        flag_mask = 4'hF;
        {alu_v, alu_c, alu_n, alu_z} = f;
        cyc();
        idle();
    endtask

    task automatic push();
        flags_push = 1'b1;
        cyc();
        idle();
    endtask

    task automatic pop();
        flags_pop = 1'b1;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_flags", 8'(flags_out), 8'h0);
        chk("rst_count", 8'(stack_count), 8'h0);
        chk("rst_err", 8'(stack_err), 8'h0);
        chk("rst_rvalid", 8'(res_valid), 8'h0);
        chk("rst_rtaken", 8'(res_taken), 8'h0);

        // Masked load then HI / CS requests
        load(4'b0101);
        chk("t1_flags", 8'(flags_out), 8'h5);
        cond_valid = 1'b1;
        cond_code  = 4'd9;
        cyc();
        chk("t1_hi_valid", 8'(res_valid), 8'h1);
        chk("t1_hi_taken", 8'(res_taken), 8'h0);
        cond_code = 4'd3;
        cyc();
        chk("t1_cs_taken", 8'(res_taken), 8'h1);
        idle();
        cyc();
        chk("t1_drain", 8'(res_valid), 8'h0);

        // Forwarding of a same-cycle partial-mask update into EQ
        load(4'b0000);
        flags_we   = 1'b1;
        flag_mask  = 4'b0001;
        {alu_v, alu_c, alu_n, alu_z} = 4'b1111;
        cond_valid = 1'b1;
        cond_code  = 4'd1;
        cyc();
        idle();
        chk("t2_eq_fwd", 8'(res_taken), 8'h1);
        chk("t2_flags", 8'(flags_out), 8'h1);

        // Stack fill, overflow, LIFO restore, underflow
        load(4'b0011); push();
        load(4'b0110); push();
        load(4'b1100); push();
        load(4'b1001); push();
        chk("t3_full", 8'(stack_count), 8'h4);
        chk("t3_noerr", 8'(stack_err), 8'h0);
        load(4'b1111);
        push();
        chk("t3_ovf_count", 8'(stack_count), 8'h4);
        chk("t3_ovf_err", 8'(stack_err), 8'h1);
        pop();
        chk("t3_pop1", 8'(flags_out), 8'h9);
        pop();
        chk("t3_pop2", 8'(flags_out), 8'hC);
        pop();
        chk("t3_pop3", 8'(flags_out), 8'h6);
        pop();
        chk("t3_pop4", 8'(flags_out), 8'h3);
        chk("t3_empty", 8'(stack_count), 8'h0);
        pop();
        chk("t3_unf_flags", 8'(flags_out), 8'h3);
        chk("t3_unf_count", 8'(stack_count), 8'h0);

        // Simultaneous push/pop; pop overriding flags_we
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        load(4'b0011); push();
        load(4'b0110); push();
        load(4'b1010);
        flags_push = 1'b1;
        flags_pop  = 1'b1;
        cyc();
        idle();
        chk("t4_pp_count", 8'(stack_count), 8'h2);
        chk("t4_pp_flags", 8'(flags_out), 8'hA);
        chk("t4_pp_err", 8'(stack_err), 8'h0);
        flags_pop = 1'b1;
        flags_we  = 1'b1;
        flag_mask = 4'hF;
        {alu_v, alu_c, alu_n, alu_z} = 4'b0000;
        cyc();
        idle();
        chk("t4_pop_wins", 8'(flags_out), 8'h6);
        chk("t4_pop_count", 8'(stack_count), 8'h1);

        // Backpressure: result held while res_ready is low
        res_ready  = 1'b0;
        cond_valid = 1'b1;
        cond_code  = 4'd3;
        cyc();
        cond_code = 4'd15;
        for (int k = 0; k < 5; k++) begin
            chk("t5_ready_low", 8'(cond_ready), 8'h0);
            chk("t5_hold_taken", 8'(res_taken), 8'h1);
            chk("t5_hold_valid", 8'(res_valid), 8'h1);
            cyc();
        end
        res_ready = 1'b1;
        #1;
        chk("t5_ready_high", 8'(cond_ready), 8'h1);
        cyc();
        chk("t5_nv_taken", 8'(res_taken), 8'h0);
        chk("t5_nv_valid", 8'(res_valid), 8'h1);
        // flags n=1,v=0: GE false, LT true, back-to-back
        cond_code = 4'd11;
        cyc();
        chk("t5_ge", 8'(res_taken), 8'h0);
        cond_code = 4'd12;
        cyc();
        chk("t5_lt", 8'(res_taken), 8'h1);
        idle();
        cyc();

        // Reset with pending result, non-empty stack and sticky error
        push(); push(); push();
        push();
        pop();
        chk("t6_pre_count", 8'(stack_count), 8'h3);
        chk("t6_pre_err", 8'(stack_err), 8'h1);
        res_ready  = 1'b0;
        cond_valid = 1'b1;
        cond_code  = 4'd0;
        cyc();
        cond_valid = 1'b0;
        chk("t6_pre_valid", 8'(res_valid), 8'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_flags", 8'(flags_out), 8'h0);
        chk("t6_count", 8'(stack_count), 8'h0);
        chk("t6_err", 8'(stack_err), 8'h0);
        chk("t6_rvalid", 8'(res_valid), 8'h0);
        chk("t6_rtaken", 8'(res_taken), 8'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
